// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the RAM ports.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    // Processor datapath side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_valid;
    // Loader / debug side
    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic [DATA_W-1:0] ldr_rdata;
    logic              ldr_valid;
    // RAM side
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rdata, cpu_valid,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rdata, ldr_valid,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    // Requesters-plus-RAM view
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rdata, cpu_valid,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rdata, ldr_valid,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the processor and the loader/debug port.
// Single-cycle grant, burst hold with a bounded streak under contention.
module ram_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic         clk,
    input logic         reset,
    ram_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HoldMax = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HoldOne = CW'(1);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnCpu  = 2'd1,
        OwnLdr  = 2'd2
    } owner_t;

    owner_t            owner_q;
    logic [CW-1:0]     hold_cnt_q;
    logic              cpu_valid_q;
    logic              ldr_valid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;
    logic              gnt_cpu;
    logic              gnt_ldr;

    // Grant selection: owner keeps the RAM until its streak expires under contention
    always_comb begin
        gnt_cpu = 1'b0;
        gnt_ldr = 1'b0;
        if (owner_q == OwnCpu && bus.cpu_req && (hold_cnt_q < HoldMax || !bus.ldr_req)) begin
            gnt_cpu = 1'b1;
        end else if (owner_q == OwnLdr && bus.ldr_req &&
                     (hold_cnt_q < HoldMax || !bus.cpu_req)) begin
            gnt_ldr = 1'b1;
        end else if (bus.cpu_req && bus.ldr_req) begin
            // Hand over to the non-owner; with no owner the processor wins
            if (owner_q == OwnCpu) gnt_ldr = 1'b1;
            else                   gnt_cpu = 1'b1;
        end else if (bus.cpu_req) begin
            gnt_cpu = 1'b1;
        end else if (bus.ldr_req) begin
            gnt_ldr = 1'b1;
        end
    end

    // Ownership, streak counter and registered read returns
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= OwnNone;
            hold_cnt_q  <= '0;
            cpu_valid_q <= 1'b0;
            ldr_valid_q <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            if (gnt_cpu) begin
                if (owner_q == OwnCpu) begin
                    if (hold_cnt_q != HoldMax) hold_cnt_q <= hold_cnt_q + HoldOne;
                end else begin
                    owner_q    <= OwnCpu;
                    hold_cnt_q <= HoldOne;
                end
            end else if (gnt_ldr) begin
                if (owner_q == OwnLdr) begin
                    if (hold_cnt_q != HoldMax) hold_cnt_q <= hold_cnt_q + HoldOne;
                end else begin
                    owner_q    <= OwnLdr;
                    hold_cnt_q <= HoldOne;
                end
            end else begin
                hold_cnt_q <= '0;
            end

            cpu_valid_q <= gnt_cpu & ~bus.cpu_we;
            ldr_valid_q <= gnt_ldr & ~bus.ldr_we;
            if (gnt_cpu && !bus.cpu_we) cpu_rdata_q <= bus.ram_rdata;
            if (gnt_ldr && !bus.ldr_we) ldr_rdata_q <= bus.ram_rdata;
        end
    end

    assign bus.cpu_gnt   = gnt_cpu;
    assign bus.ldr_gnt   = gnt_ldr;
    assign bus.cpu_stall = bus.cpu_req & ~gnt_cpu;

    // A result already in flight when reset rises is suppressed, not delivered
    assign bus.cpu_valid = cpu_valid_q & ~reset;
    assign bus.ldr_valid = ldr_valid_q & ~reset;
    assign bus.cpu_rdata = reset ? '0 : cpu_rdata_q;
    assign bus.ldr_rdata = reset ? '0 : ldr_rdata_q;

    // RAM drive: processor is the default address source when idle
    assign bus.ram_addr  = gnt_ldr ? bus.ldr_addr  : bus.cpu_addr;
    assign bus.ram_wdata = gnt_ldr ? bus.ldr_wdata : bus.cpu_wdata;
    assign bus.ram_we    = ~reset & ((gnt_cpu & bus.cpu_we) | (gnt_ldr & bus.ldr_we));
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, behavioural arbiter model, directed vectors.
module tb_ram_arbiter;
    localparam int unsigned MAX_HOLD = 4;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    ram_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small RAM: combinational read, write on rising edge
    logic [15:0] ram [0:255];
    always_comb bus.ram_rdata = ram[bus.ram_addr[7:0]];
    always @(posedge clk) if (bus.ram_we) ram[bus.ram_addr[7:0]] <= bus.ram_wdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: who used the RAM last, how long the current streak is
    logic [15:0] m_mem [int];
    int          m_last;   // 0 nobody yet, 1 processor, 2 loader
    int          m_streak;
    bit          m_cv, m_lv;
    logic [15:0] m_cd, m_ld;
    int          eg;
    logic        e_we;
    logic [15:0] e_addr, e_wd;

    function automatic logic [15:0] m_read(input logic [15:0] a);
        return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 16'h0;
    endfunction

    always @(negedge clk) begin
        // Incumbent keeps going unless its streak is used up while the other waits
        eg = 0;
        if (m_last == 1 && bus.cpu_req && (!bus.ldr_req || m_streak < MAX_HOLD)) eg = 1;
        else if (m_last == 2 && bus.ldr_req && (!bus.cpu_req || m_streak < MAX_HOLD)) eg = 2;
        else if (bus.cpu_req && bus.ldr_req) eg = (m_last == 1) ? 2 : 1;
        else if (bus.cpu_req) eg = 1;
        else if (bus.ldr_req) eg = 2;

        e_we   = !reset && ((eg == 1 && bus.cpu_we) || (eg == 2 && bus.ldr_we));
        e_addr = (eg == 2) ? bus.ldr_addr : bus.cpu_addr;
        e_wd   = (eg == 2) ? bus.ldr_wdata : bus.cpu_wdata;

        chk("m_cpu_gnt", {31'b0, bus.cpu_gnt}, {31'b0, eg == 1});
        chk("m_ldr_gnt", {31'b0, bus.ldr_gnt}, {31'b0, eg == 2});
        chk("m_cpu_stall", {31'b0, bus.cpu_stall}, {31'b0, bus.cpu_req && eg != 1});
        chk("m_ram_we", {31'b0, bus.ram_we}, {31'b0, e_we});
        chk("m_ram_addr", {16'b0, bus.ram_addr}, {16'b0, e_addr});
        chk("m_ram_wdata", {16'b0, bus.ram_wdata}, {16'b0, e_wd});
        chk("m_cpu_valid", {31'b0, bus.cpu_valid}, {31'b0, m_cv && !reset});
        chk("m_ldr_valid", {31'b0, bus.ldr_valid}, {31'b0, m_lv && !reset});
        chk("m_cpu_rdata", {16'b0, bus.cpu_rdata}, {16'b0, reset ? 16'h0 : m_cd});
        chk("m_ldr_rdata", {16'b0, bus.ldr_rdata}, {16'b0, reset ? 16'h0 : m_ld});

        // Advance to the state after the coming rising edge
        if (reset) begin
            m_last = 0; m_streak = 0; m_cv = 0; m_lv = 0; m_cd = '0; m_ld = '0;
        end else begin
            m_cv = (eg == 1) && !bus.cpu_we;
            m_lv = (eg == 2) && !bus.ldr_we;
            if (m_cv) m_cd = m_read(bus.cpu_addr);
            if (m_lv) m_ld = m_read(bus.ldr_addr);
            if (e_we) m_mem[int'(e_addr)] = e_wd;
            if (eg == 0) m_streak = 0;
            else if (eg == m_last) m_streak = (m_streak < MAX_HOLD) ? m_streak + 1 : MAX_HOLD;
            else begin
                m_last = eg; m_streak = 1;
            end
        end
    end

    task automatic set_cpu(input logic req, input logic we, input logic [15:0] a,
                           input logic [15:0] d);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic set_ldr(input logic req, input logic we, input logic [15:0] a,
                           input logic [15:0] d);
        bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = a; bus.ldr_wdata = d;
    endtask

    // Next cycle: inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        m_last = 0; m_streak = 0; m_cv = 0; m_lv = 0; m_cd = '0; m_ld = '0;
        for (int i = 0; i < 256; i++) ram[i] = 16'h0;
        ram[8'h10] = 16'hBEEF; m_mem[16'h10] = 16'hBEEF;
        ram[8'h30] = 16'h5A5A; m_mem[16'h30] = 16'h5A5A;
        reset = 1'b1;
        set_cpu(0, 0, 16'h0, 16'h0);
        set_ldr(0, 0, 16'h0, 16'h0);

        // Reset, idle requesters
        step(); step();
        #3;
        chk("rst_cpu_gnt", {31'b0, bus.cpu_gnt}, 32'd0);
        chk("rst_ldr_gnt", {31'b0, bus.ldr_gnt}, 32'd0);
        chk("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
        chk("rst_cpu_valid", {31'b0, bus.cpu_valid}, 32'd0);
        chk("rst_cpu_rdata", {16'b0, bus.cpu_rdata}, 32'd0);
        chk("rst_cpu_stall", {31'b0, bus.cpu_stall}, 32'd0);
        step();

        // Processor-only read of 0x0010
        reset = 1'b0;
        set_cpu(1, 0, 16'h0010, 16'h0);
        #3 chk("rd_gnt", {31'b0, bus.cpu_gnt}, 32'd1);
        step();
        set_cpu(0, 0, 16'h0, 16'h0);
        #3;
        chk("rd_valid", {31'b0, bus.cpu_valid}, 32'd1);
        chk("rd_data", {16'b0, bus.cpu_rdata}, 32'h0000BEEF);
        step();
        #3 chk("rd_valid_drop", {31'b0, bus.cpu_valid}, 32'd0);
        step();

        // Contention from reset: 4-cycle bursts alternate
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        set_cpu(1, 0, 16'h0010, 16'h0);
        set_ldr(1, 0, 16'h0030, 16'h0);
        for (int c = 0; c < 12; c++) begin
            #3;
            chk($sformatf("rr_cpu_gnt_%0d", c), {31'b0, bus.cpu_gnt},
                {31'b0, (c < 4 || c >= 8)});
            chk($sformatf("rr_stall_%0d", c), {31'b0, bus.cpu_stall},
                {31'b0, (c >= 4 && c < 8)});
            step();
        end
        set_cpu(0, 0, 16'h0, 16'h0);
        set_ldr(0, 0, 16'h0, 16'h0);
        step();

        // Loader write then processor read of the same word
        set_ldr(1, 1, 16'h0020, 16'h1234);
        #3;
        chk("wr_ram_we", {31'b0, bus.ram_we}, 32'd1);
        chk("wr_ldr_gnt", {31'b0, bus.ldr_gnt}, 32'd1);
        step();
        set_ldr(0, 0, 16'h0, 16'h0);
        set_cpu(1, 0, 16'h0020, 16'h0);
        #3 chk("wr_rd_ram_we", {31'b0, bus.ram_we}, 32'd0);
        step();
        set_cpu(0, 0, 16'h0, 16'h0);
        #3;
        chk("wr_rd_valid", {31'b0, bus.cpu_valid}, 32'd1);
        chk("wr_rd_data", {16'b0, bus.cpu_rdata}, 32'h00001234);
        chk("wr_no_ldr_valid", {31'b0, bus.ldr_valid}, 32'd0);
        step();

        // Lone processor streak, then the loader arrives
        set_cpu(1, 0, 16'h0010, 16'h0);
        for (int c = 0; c < 10; c++) begin
            #3 chk($sformatf("lone_gnt_%0d", c), {31'b0, bus.cpu_gnt}, 32'd1);
            step();
        end
        set_ldr(1, 0, 16'h0020, 16'h0);
        #3;
        chk("late_ldr_gnt", {31'b0, bus.ldr_gnt}, 32'd1);
        chk("late_cpu_stall", {31'b0, bus.cpu_stall}, 32'd1);
        step();
        set_cpu(0, 0, 16'h0, 16'h0);
        set_ldr(0, 0, 16'h0, 16'h0);
        step(); step();

        // Reset lands while a read result is in flight; a write is pending too
        set_cpu(1, 0, 16'h0010, 16'h0);
        #3 chk("mid_gnt", {31'b0, bus.cpu_gnt}, 32'd1);
        step();
        reset = 1'b1;
        set_cpu(1, 1, 16'h0030, 16'hDEAD);
        #3;
        chk("mid_valid", {31'b0, bus.cpu_valid}, 32'd0);
        chk("mid_rdata", {16'b0, bus.cpu_rdata}, 32'd0);
        chk("mid_ram_we", {31'b0, bus.ram_we}, 32'd0);
        chk("mid_rst_gnt", {31'b0, bus.cpu_gnt}, 32'd1);
        step();
        reset = 1'b0;
        set_cpu(0, 0, 16'h0, 16'h0);
        #3;
        chk("post_valid", {31'b0, bus.cpu_valid}, 32'd0);
        chk("post_rdata", {16'b0, bus.cpu_rdata}, 32'd0);
        step();
        set_cpu(1, 0, 16'h0030, 16'h0);
        step();
        set_cpu(0, 0, 16'h0, 16'h0);
        #3;
        chk("post_rd_valid", {31'b0, bus.cpu_valid}, 32'd1);
        chk("post_rd_data", {16'b0, bus.cpu_rdata}, 32'h00005A5A);
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters: the processor datapath (fetch, load, store) and a program loader/debug port.
- Sits between both requesters and the RAM's write_EN, read_address/write_address, write_value and word ports.
- Arbitration is single-cycle, with burst hold and bounded round-robin fairness.
- Drives a stall indication back to the processor control.

Parameters:
ADDR_W, 16, address width of RAM and requester ports
DATA_W, 16, data word width
MAX_HOLD, 4, max consecutive grants to one requester while the other is requesting (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  processor requests a RAM access this cycle
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  processor access address
cpu_wdata  input  DATA_W  processor write data
cpu_gnt  output  1  processor access performed this cycle
cpu_stall  output  1  cpu_req & ~cpu_gnt
cpu_rdata  output  DATA_W  registered read data
cpu_valid  output  1  cpu_rdata valid, one-cycle pulse
ldr_req  input  1  loader requests a RAM access
ldr_we  input  1  1 = write, 0 = read
ldr_addr  input  ADDR_W  loader address
ldr_wdata  input  DATA_W  loader write data
ldr_gnt  output  1  loader access performed this cycle
ldr_rdata  output  DATA_W  registered read data
ldr_valid  output  1  ldr_rdata valid, one-cycle pulse
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM read/write address
ram_wdata  output  DATA_W  RAM write value
ram_rdata  input  DATA_W  RAM combinational read word

Behaviour:
- State registers:
  - owner: NONE/CPU/LDR, reset NONE.
  - hold_cnt: 0..MAX_HOLD, saturating, reset 0.
  - cpu_valid, ldr_valid, cpu_rdata, ldr_rdata: all reset 0.
- Grant is combinational from the request inputs and registered state. At most one grant per cycle.
  - owner==CPU, cpu_req, and (hold_cnt<MAX_HOLD or !ldr_req): grant CPU. Symmetric rule for LDR.
  - Otherwise, both requesting: grant the requester that is not owner; owner NONE grants CPU.
  - Otherwise: grant the sole requester, or none.
- RAM drive:
  - ram_addr/ram_wdata come from the granted requester; with no grant they come from CPU.
  - ram_we = granted requester's we; ram_we is 0 when nothing is granted.
- Read data: on a granted read, ram_rdata is captured into that requester's rdata at the clock edge, and its valid pulses high the following cycle for exactly one cycle. Latency is 1 cycle from grant.
- Writes produce no valid pulse, and the rdata register holds its previous value.
- Update on edge:
  - Grant to the current owner: hold_cnt <= min(hold_cnt+1, MAX_HOLD).
  - Grant to the other requester: owner <= granted, hold_cnt <= 1.
  - No grant: owner unchanged, hold_cnt <= 0.
- A requester not granted must hold req/we/addr/wdata stable until granted. The arbiter does not queue requests.
- Lone requester: granted every cycle indefinitely; MAX_HOLD applies only under contention.
- Write then read of the same address in consecutive cycles returns the newly written data.
- Reset mid-operation: an in-flight read result is dropped, valid does not pulse, and all registers return to reset values. Grants are still computed combinationally during reset, but the RAM write is blocked (ram_we forced 0 while reset=1).

Test Plan:
- Reset for 2 cycles with idle requests -> all outputs 0, owner NONE.
- CPU-only read, cpu_addr=0x0010, RAM[0x0010]=0xBEEF -> cpu_gnt=1 same cycle; next cycle cpu_valid=1, cpu_rdata=0xBEEF; following cycle cpu_valid=0.
- Both request continuously from reset, MAX_HOLD=4 -> cpu_gnt cycles 0-3, ldr_gnt 4-7, cpu_gnt 8-11; cpu_stall=1 exactly during 4-7.
- LDR writes 0x1234 to 0x0020 in cycle 0; CPU reads 0x0020 in cycle 1 -> ram_we=1 only in cycle 0; cpu_rdata=0x1234, cpu_valid in cycle 2.
- CPU alone requests 10 cycles -> granted all 10, hold_cnt saturates at 4. LDR then requests in cycle 10 with CPU still requesting -> ldr_gnt in cycle 10.
- Granted CPU read in cycle 5, reset asserted in cycle 6 -> cpu_valid stays 0, cpu_rdata=0; no RAM write occurs during reset.
